wb_mem_tester_32: RTL and testbench
===================================

Name: wb_mem_tester_32

Overview:
- Wishbone master that fills a DDR region with a deterministic pattern, reads it back and compares every word.
- Sits directly upstream of the 32-bit Wishbone-to-MCB bridge and drives its Wishbone slave port.
- Used for bring-up and self-test of external memory.
- Issues single, non-pipelined classic-cycle accesses: one word per transaction, full byte selects.

Parameters:
- TIMEOUT, 1024: cycles to wait for wb_ack_i before aborting a transaction; 0 disables the timeout.
- COUNT_WIDTH, 24: width of word_count and of the internal word index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a test when idle.
- base_addr  in  32  byte address of the first word; bits [1:0] are ignored (forced to 0).
- word_count  in  COUNT_WIDTH  number of 32-bit words to test.
- mode  in  2  pattern select (see Behaviour).
- seed  in  32  pattern seed.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at test end.
- pass  out  1  valid when done; high if err_count==0 and no timeout.
- timeout  out  1  sticky until next start; high if a transaction was aborted.
- err_count  out  16  mismatch count, saturating at 16'hFFFF.
- first_err_addr  out  32  byte address of the first mismatch.
- first_err_data  out  32  data read at the first mismatch.
- wb_adr_o  out  32  Wishbone address.
- wb_dat_o  out  32  Wishbone write data.
- wb_dat_i  in  32  Wishbone read data.
- wb_we_o  out  1  Wishbone write enable.
- wb_sel_o  out  4  Wishbone byte selects; always 4'hF when strobing.
- wb_stb_o  out  1  Wishbone strobe.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_cyc_o  out  1  Wishbone cycle.

Behaviour:
- Reset values:
  - Wishbone outputs: all 0.
  - busy, done, pass, timeout: 0.
  - err_count: 0.
  - first_err_addr, first_err_data: 0.
  - State: IDLE.
- Reset mid-operation: wb_cyc_o and wb_stb_o drop at the next edge; no further access is issued.
- Pattern for word index i (modulo 2^32), with a = base_addr + 4*i:
  - mode 0: seed.
  - mode 1: seed + i.
  - mode 2: a.
  - mode 3: ~(seed + i).
- Address arithmetic is 32-bit and wraps from 32'hFFFF_FFFC to 0.
- States: IDLE, WR, WR_GAP, RD, RD_GAP, FIN.
- IDLE:
  - On start, latch base_addr, word_count, mode and seed.
  - Clear err_count, timeout, first_err_addr and first_err_data; set busy.
  - If word_count==0, go to FIN. Otherwise set i=0 and go to WR.
- start while busy is ignored.
- WR:
  - Assert cyc, stb, we=1, sel=F, adr=a, dat=pattern(i).
  - Hold these until wb_ack_i.
  - On the ack cycle, cyc and stb are cleared at that edge; the next state is WR_GAP.
  - The master never presents stb in the cycle after an ack, because the bridge samples stb against its own registered ack.
- WR_GAP (one idle cycle):
  - If i==word_count-1, set i=0 and go to RD.
  - Otherwise increment i and go to WR.
- RD:
  - Assert cyc, stb, we=0, sel=F, adr=a.
  - On ack, compare wb_dat_i with pattern(i).
  - On mismatch, err_count increments (saturating).
  - On the first mismatch, capture a and wb_dat_i.
  - Next state is RD_GAP.
- RD_GAP: same sequencing as WR_GAP; after the last word go to FIN.
- Timeout (TIMEOUT != 0):
  - Per-transaction counter starts when stb rises.
  - If TIMEOUT cycles pass without ack, drop cyc and stb, set timeout, go to FIN.
  - An ack arriving in the same cycle the count expires is accepted; no timeout.
- FIN:
  - One-cycle done pulse; busy clears in the same cycle.
  - pass = (err_count==0) & ~timeout.
  - Return to IDLE.
- wb_ack_i outside an active strobe is ignored.
- Latency per word (zero-wait slave, ack registered one cycle after stb): 3 cycles per write, 3 cycles per read.

Decomposition:
- Shared package wb_mem_tester_pkg holds:
  - state encodings;
  - mode constants MODE_CONST, MODE_INC, MODE_ADDR, MODE_INV_INC;
  - ERR_SAT = 16'hFFFF.
- One combinational sub-module, wb_mem_pattern (inputs: mode, seed, index, addr; output: data), shared by the write path and the compare path.

Test Plan:
- Zero-wait memory model, base 32'h0000_1000, count 4, mode 1, seed 32'h10:
  - Writes 0x10..0x13 go to 0x1000..0x100C.
  - done with pass=1, err_count=0.
- Same setup, model corrupts the read of 0x1008 to 32'hDEAD_BEEF:
  - err_count=1, first_err_addr=0x1008, first_err_data=0xDEADBEEF, pass=0.
- Slave with 5-cycle ack latency:
  - stb stays asserted until ack.
  - Exactly one idle cycle with stb=0 follows every ack.
  - No duplicate transactions.
- TIMEOUT=16, slave never acks:
  - stb drops 16 cycles after rising; timeout=1, pass=0, done pulses.
- Edge cases:
  - word_count=0 gives done one cycle after start with pass=1 and no cyc.
  - base 32'hFFFF_FFFC, count 2, mode 2: second address is 0.
- Reset and start handling:
  - rst asserted during RD gives cyc=stb=busy=0 next cycle.
  - start pulsed while busy is ignored: the original count completes.

Source files
------------

// File: rtl/wb_mem_tester_pkg.sv
// wb_mem_tester_pkg: shared state encoding, pattern modes and saturation limit for the memory tester
package wb_mem_tester_pkg;
  typedef enum logic [2:0] {IDLE, WR, WR_GAP, RD, RD_GAP, FIN} state_t;
  localparam logic [1:0] MODE_CONST = 2'd0;
  localparam logic [1:0] MODE_INC = 2'd1;
  localparam logic [1:0] MODE_ADDR = 2'd2;
  localparam logic [1:0] MODE_INV_INC = 2'd3;
  localparam logic [15:0] ERR_SAT = 16'hFFFF;
endpackage

// File: rtl/wb_mem_pattern.sv
// wb_mem_pattern: test data for one word, shared by the write path and the read-back compare
module wb_mem_pattern
  import wb_mem_tester_pkg::*;
(
  input  logic [1:0]  mode,
  input  logic [31:0] seed,
  input  logic [31:0] index,
  input  logic [31:0] addr,
  output logic [31:0] data
);
  always_comb data = mode == MODE_CONST ? seed :
                     mode == MODE_INC   ? seed + index :
                     mode == MODE_ADDR  ? addr : ~(seed + index);
endmodule

// File: rtl/wb_mem_tester_32.sv
// wb_mem_tester_32: Wishbone master that fills a memory region with a pattern, reads it back and counts mismatches
module wb_mem_tester_32
  import wb_mem_tester_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int COUNT_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [31:0]            base_addr,
  input  logic [COUNT_WIDTH-1:0] word_count,
  input  logic [1:0]             mode,
  input  logic [31:0]            seed,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [15:0]            err_count,
  output logic [31:0]            first_err_addr,
  output logic [31:0]            first_err_data,
  output logic [31:0]            wb_adr_o,
  output logic [31:0]            wb_dat_o,
  input  logic [31:0]            wb_dat_i,
  output logic                   wb_we_o,
  output logic [3:0]             wb_sel_o,
  output logic                   wb_stb_o,
  input  logic                   wb_ack_i,
  output logic                   wb_cyc_o
);
  state_t state_q, state_d;
  logic [COUNT_WIDTH-1:0] idx_q, idx_d, cnt_q, cnt_d;
  logic [1:0] mode_q, mode_d;
  logic [31:0] seed_q, seed_d, base_q, base_d, addr_q, addr_d, tmo_q, tmo_d;
  logic [31:0] fea_q, fea_d, fed_q, fed_d, pat;
  logic [15:0] err_q, err_d;
  logic timeout_q, timeout_d, strobe, ack, expire, last, mismatch;
  wb_mem_pattern u_pattern (
    .mode  (mode_q),
    .seed  (seed_q),
    .index (32'(idx_q)),
    .addr  (addr_q),
    .data  (pat)
  );
  assign strobe = state_q == WR || state_q == RD;
  assign ack = strobe && wb_ack_i;
  assign expire = TIMEOUT != 0 && tmo_q == 32'(TIMEOUT - 1);
  assign last = idx_q == cnt_q - 1'b1;
  assign mismatch = wb_dat_i != pat;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    mode_d = mode_q;
    seed_d = seed_q;
    base_d = base_q;
    addr_d = addr_q;
    err_d = err_q;
    fea_d = fea_q;
    fed_d = fed_q;
    timeout_d = timeout_q;
    tmo_d = strobe ? tmo_q + 32'd1 : '0;
    unique case (state_q)
      IDLE: if (start) begin
        base_d = {base_addr[31:2], 2'b00};
        addr_d = {base_addr[31:2], 2'b00};
        cnt_d = word_count;
        mode_d = mode;
        seed_d = seed;
        idx_d = '0;
        err_d = '0;
        fea_d = '0;
        fed_d = '0;
        timeout_d = 1'b0;
        state_d = word_count == '0 ? FIN : WR;
      end
      WR, RD: if (ack) begin
        if (state_q == RD && mismatch) begin
          err_d = err_q == ERR_SAT ? err_q : err_q + 16'd1;
          fea_d = err_q == '0 ? addr_q : fea_q;
          fed_d = err_q == '0 ? wb_dat_i : fed_q;
        end
        state_d = state_q == WR ? WR_GAP : RD_GAP;
      end else if (expire) begin
        timeout_d = 1'b1;
        state_d = FIN;
      end
      WR_GAP, RD_GAP: begin
        idx_d = last ? '0 : idx_q + 1'b1;
        addr_d = last ? base_q : addr_q + 32'd4;
        state_d = state_q == WR_GAP ? (last ? RD : WR) : (last ? FIN : RD);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      mode_q <= '0;
      seed_q <= '0;
      base_q <= '0;
      addr_q <= '0;
      tmo_q <= '0;
      err_q <= '0;
      fea_q <= '0;
      fed_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      mode_q <= mode_d;
      seed_q <= seed_d;
      base_q <= base_d;
      addr_q <= addr_d;
      tmo_q <= tmo_d;
      err_q <= err_d;
      fea_q <= fea_d;
      fed_q <= fed_d;
      timeout_q <= timeout_d;
    end
  end
  assign busy = state_q inside {WR, WR_GAP, RD, RD_GAP};
  assign done = state_q == FIN;
  assign pass = done && err_q == '0 && !timeout_q;
  assign timeout = timeout_q;
  assign err_count = err_q;
  assign first_err_addr = fea_q;
  assign first_err_data = fed_q;
  assign wb_cyc_o = strobe;
  assign wb_stb_o = strobe;
  assign wb_we_o = state_q == WR;
  assign wb_sel_o = strobe ? 4'hF : 4'h0;
  assign wb_adr_o = strobe ? addr_q : '0;
  assign wb_dat_o = state_q == WR ? pat : '0;
endmodule

// File: tb/tb_wb_mem_tester_32.sv
// tb_wb_mem_tester_32: directed tests against a memory slave model and a transaction-level expectation model
module tb_wb_mem_tester_32;
  localparam int TMO = 16;
  typedef struct {logic we; logic [31:0] adr; logic [31:0] dat;} txn_t;
  logic clk = 0, rst = 1, start = 0;
  logic [31:0] base_addr = 0, seed = 0;
  logic [23:0] word_count = 0;
  logic [1:0] mode = 0;
  logic busy, done, pass, timeout, wb_we_o, wb_stb_o, wb_cyc_o;
  logic [15:0] err_count;
  logic [31:0] first_err_addr, first_err_data, wb_adr_o, wb_dat_o;
  logic [3:0] wb_sel_o;
  logic [31:0] wb_dat_i = 0;
  logic wb_ack_i = 0;
  wb_mem_tester_32 #(.TIMEOUT(TMO), .COUNT_WIDTH(24)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .mode(mode), .seed(seed), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_addr(first_err_addr), .first_err_data(first_err_data),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_cyc_o(wb_cyc_o)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, dones = 0, run_len = 0, last_run = 0;
  int lat = 1, wcnt = 0, exp_err = 0, exp_cyc = 0;
  bit never = 0, corr = 0, exp_to = 0, exp_pass = 0;
  logic [31:0] caddr = 0, cval = 0, exp_fea = 0, exp_fed = 0;
  logic [31:0] mem [256];
  txn_t exp_q[$];
  logic [31:0] obs_wa[$], obs_wd[$];
  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endfunction
  function automatic logic [31:0] pat(input logic [1:0] m, input logic [31:0] s, input int i, input logic [31:0] a);
    case (m)
      2'd0: return s;
      2'd1: return s + 32'(i);
      2'd2: return a;
      default: return ~(s + 32'(i));
    endcase
  endfunction
  always @(posedge clk) begin
    if (rst || !wb_stb_o || wb_ack_i) begin
      wb_ack_i <= 0;
      wcnt <= 0;
    end else begin
      wcnt <= wcnt + 1;
      if (!never && wcnt == lat - 1) begin
        wb_ack_i <= 1;
        if (wb_we_o) mem[wb_adr_o[9:2]] <= wb_dat_o;
        else wb_dat_i <= (corr && wb_adr_o == caddr) ? cval : mem[wb_adr_o[9:2]];
      end
    end
  end
  logic prev_ack = 0, prev_stb = 0, prev_we = 0;
  logic [31:0] prev_adr = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_ack <= 0;
      prev_stb <= 0;
      run_len <= 0;
    end else begin
      if (wb_stb_o) begin
        chk("cyc_with_stb", wb_cyc_o, 1);
        chk("sel", wb_sel_o, 4'hF);
      end
      if (prev_ack) chk("idle_after_ack", wb_stb_o, 0);
      if (prev_stb && !prev_ack && wb_stb_o) begin
        chk("hold_adr", wb_adr_o, prev_adr);
        chk("hold_we", wb_we_o, prev_we);
      end
      if (wb_stb_o && wb_ack_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_txn: got access at %h, expected none", wb_adr_o);
        end else begin
          chk("txn_adr", wb_adr_o, exp_q[0].adr);
          chk("txn_we", wb_we_o, exp_q[0].we);
          if (exp_q[0].we) chk("txn_dat", wb_dat_o, exp_q[0].dat);
          exp_q.delete(0);
        end
        if (wb_we_o) begin
          obs_wa.push_back(wb_adr_o);
          obs_wd.push_back(wb_dat_o);
        end
      end
      if (done) begin
        chk("pass", pass, exp_pass);
        chk("err_count", err_count, 32'(exp_err));
        chk("first_err_addr", first_err_addr, exp_fea);
        chk("first_err_data", first_err_data, exp_fed);
        chk("timeout", timeout, exp_to);
        chk("busy_at_done", busy, 0);
        chk("cyc_at_done", wb_cyc_o, 0);
        dones <= dones + 1;
      end
      prev_ack <= wb_stb_o && wb_ack_i;
      prev_stb <= wb_stb_o;
      prev_we <= wb_we_o;
      prev_adr <= wb_adr_o;
      run_len <= wb_stb_o ? run_len + 1 : 0;
      if (!wb_stb_o && run_len != 0) last_run <= run_len;
    end
  end
  task automatic setup(input logic [31:0] b, input int n, input logic [1:0] m, input logic [31:0] s,
                       input int l, input bit nv, input bit ce, input logic [31:0] ca, input logic [31:0] cv);
    logic [31:0] a, p, r;
    base_addr = b;
    word_count = 24'(n);
    mode = m;
    seed = s;
    lat = l;
    never = nv;
    corr = ce;
    caddr = ca;
    cval = cv;
    exp_q.delete();
    obs_wa.delete();
    obs_wd.delete();
    exp_err = 0;
    exp_fea = 0;
    exp_fed = 0;
    exp_to = nv;
    exp_cyc = nv ? TMO : 2 * n * (l + 2);
    if (!nv) for (int k = 0; k < 2; k++) for (int i = 0; i < n; i++) begin
      a = {b[31:2], 2'b00} + 32'(4 * i);
      p = pat(m, s, i, a);
      exp_q.push_back('{we: k == 0, adr: a, dat: p});
      r = (ce && a == ca) ? cv : p;
      if (k == 1 && r != p) begin
        if (exp_err == 0) begin
          exp_fea = a;
          exp_fed = r;
        end
        exp_err++;
      end
    end
    exp_pass = exp_err == 0 && !nv;
  endtask
  task automatic launch();
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 3000) begin
      @(posedge clk);
      #1 n++;
    end
  endtask
  task automatic finish_run(input string nm, input int d0);
    @(negedge clk);
    #1;
    chk({nm, ":done_pulses"}, 32'(dones - d0), 1);
    chk({nm, ":pending_txns"}, 32'(exp_q.size()), 0);
    @(posedge clk);
    #1 chk({nm, ":done_one_cycle"}, done, 0);
  endtask
  task automatic run(input string nm, output int n);
    int d0;
    d0 = dones;
    launch();
    wait_done(n);
    chk({nm, ":cycles"}, 32'(n), 32'(exp_cyc));
    finish_run(nm, d0);
  endtask
  initial begin
    int n, d0, bad;
    repeat (3) @(posedge clk);
    #1;
    chk("rst:busy", busy, 0);
    chk("rst:done", done, 0);
    chk("rst:pass", pass, 0);
    chk("rst:timeout", timeout, 0);
    chk("rst:err_count", err_count, 0);
    chk("rst:first_err_addr", first_err_addr, 0);
    chk("rst:first_err_data", first_err_data, 0);
    chk("rst:cyc", wb_cyc_o, 0);
    chk("rst:stb", wb_stb_o, 0);
    chk("rst:we", wb_we_o, 0);
    chk("rst:sel", wb_sel_o, 0);
    chk("rst:adr", wb_adr_o, 0);
    chk("rst:dat", wb_dat_o, 0);
    rst = 0;
    setup(32'h1000, 4, 2'd1, 32'h10, 1, 0, 0, 0, 0);
    run("inc", n);
    chk("inc:cycles_lit", 32'(n), 24);
    chk("inc:wa0", obs_wa[0], 32'h1000);
    chk("inc:wd0", obs_wd[0], 32'h10);
    chk("inc:wa3", obs_wa[3], 32'h100C);
    chk("inc:wd3", obs_wd[3], 32'h13);
    chk("inc:err_lit", err_count, 0);
    setup(32'h1000, 4, 2'd1, 32'h10, 1, 0, 1, 32'h1008, 32'hDEAD_BEEF);
    run("corrupt", n);
    chk("corrupt:err_lit", err_count, 1);
    chk("corrupt:fea_lit", first_err_addr, 32'h1008);
    chk("corrupt:fed_lit", first_err_data, 32'hDEAD_BEEF);
    setup(32'h400, 3, 2'd3, 32'hA5A5_0000, 5, 0, 0, 0, 0);
    run("slow", n);
    chk("slow:cycles_lit", 32'(n), 42);
    chk("slow:stb_len", 32'(last_run), 6);
    setup(32'h0, 2, 2'd0, 32'h1234_5678, 1, 1, 0, 0, 0);
    run("tmo", n);
    chk("tmo:stb_len", 32'(last_run), 16);
    chk("tmo:sticky", timeout, 1);
    setup(32'h0, 0, 2'd0, 32'h1, 1, 0, 0, 0, 0);
    run("zero", n);
    chk("zero:cycles_lit", 32'(n), 0);
    chk("zero:timeout_cleared", timeout, 0);
    setup(32'hFFFF_FFFC, 2, 2'd2, 32'h0, 1, 0, 0, 0, 0);
    run("wrap", n);
    chk("wrap:wa0", obs_wa[0], 32'hFFFF_FFFC);
    chk("wrap:wa1", obs_wa[1], 32'h0);
    chk("wrap:wd0", obs_wd[0], 32'hFFFF_FFFC);
    setup(32'h2003, 2, 2'd2, 32'h0, 2, 0, 0, 0, 0);
    run("unaligned", n);
    chk("unaligned:wa0", obs_wa[0], 32'h2000);
    setup(32'h800, 3, 2'd0, 32'hCAFE_F00D, 1, 0, 0, 0, 0);
    d0 = dones;
    launch();
    repeat (3) @(posedge clk);
    #1 word_count = 24'd1;
    start = 1;
    chk("restart:busy", busy, 1);
    @(posedge clk);
    #1 start = 0;
    wait_done(n);
    chk("restart:cycles", 32'(n + 4), 32'(exp_cyc));
    finish_run("restart", d0);
    setup(32'h1000, 4, 2'd1, 32'h10, 2, 0, 0, 0, 0);
    launch();
    n = 0;
    while (!(wb_stb_o && !wb_we_o) && n < 500) begin
      @(posedge clk);
      #1 n++;
    end
    chk("rstrd:reached_read", wb_stb_o && !wb_we_o, 1);
    rst = 1;
    @(posedge clk);
    #1;
    chk("rstrd:cyc", wb_cyc_o, 0);
    chk("rstrd:stb", wb_stb_o, 0);
    chk("rstrd:busy", busy, 0);
    rst = 0;
    exp_q.delete();
    bad = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (wb_cyc_o || wb_stb_o || busy) bad++;
    end
    chk("rstrd:no_access", 32'(bad), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
